// File: rtl/conv_wr_pkg.sv
// Shared types and helpers for the convolution result writer.
// Holds the write FSM encoding, the 4KB page size and the burst-length calculation.
package conv_wr_pkg;

   typedef enum logic [1:0] {StIdle, StWait, StBurst, StDone} wr_state_e;

   localparam int unsigned BOUNDARY_4K = 4096;

   // Beats for the next burst: limited by MAX_BURST, the words still owed and the 4KB page end.
   function automatic logic [15:0] calc_blen(input logic [11:0]  addr_lo,
                                             input logic [15:0]  left,
                                             input int unsigned  max_burst,
                                             input int unsigned  bytes_per_word);
      int unsigned to_4k;
      int unsigned len;
      to_4k = (BOUNDARY_4K - 32'(addr_lo)) / bytes_per_word;
      len   = max_burst;
      if (32'(left) < len) len = 32'(left);
      if (to_4k < len) len = to_4k;
      return len[15:0];
   endfunction

endpackage

// File: rtl/conv_result_writer_if.sv
// Write-burst bus between the result writer (master) and external memory (slave).
// addr/len describe the whole burst; wdata/wstrb carry the current beat.
interface conv_result_writer_if #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned AXI_ADDR_W = 32
);
   logic                  valid;
   logic [AXI_ADDR_W-1:0] addr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic [7:0]            len;
   logic                  ready;
   logic                  last;

   modport master (output valid, addr, wdata, wstrb, len, input ready, last);
   modport slave  (input valid, addr, wdata, wstrb, len, output ready, last);
endinterface

// File: rtl/conv_wr_fifo.sv
// Synchronous result FIFO with level output and synchronous clear.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module conv_wr_fifo #(
   parameter int unsigned  DATA_W = 32,
   parameter int unsigned  DEPTH  = 16,
   localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clear,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_head,
   output logic              o_full,
   output logic              o_empty,
   output logic [PTR_W:0]    o_level
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W:0]    r_wr_ptr;
   logic [PTR_W:0]    r_rd_ptr;
   logic              w_push;
   logic              w_pop;

   assign o_level = r_wr_ptr - r_rd_ptr;
   assign o_full  = (o_level == (PTR_W+1)'(DEPTH));
   assign o_empty = (o_level == '0);
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push && !i_clear) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
   end

endmodule

// File: rtl/conv_result_writer.sv
// Samples the convolution result stream on a delay/period schedule, shifts and clamps it,
// buffers it and writes it out as bursts that never cross a 4KB page.
module conv_result_writer
   import conv_wr_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned AXI_ADDR_W = 32,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned MAX_BURST  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_run,
   output logic                  o_done,
   input  logic [DATA_W-1:0]     i_in0,
   input  logic [AXI_ADDR_W-1:0] i_ext_addr,
   input  logic [15:0]           i_amount,
   input  logic [9:0]            i_period,
   input  logic [31:0]           i_delay0,
   input  logic [4:0]            i_shift,
   input  logic                  i_relu,
   output logic                  o_overflow,
   conv_result_writer_if.master  databus
);

   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BYTES = DATA_W / 8;

   // Capture side
   logic [31:0]                r_delay_cnt;
   logic [9:0]                 r_period;
   logic [15:0]                r_cap_left;
   logic                       r_cap_active;
   logic [4:0]                 r_shift;
   logic                       r_relu;
   logic                       r_stage_vld;
   logic [DATA_W-1:0]          r_stage_data;
   logic                       r_overflow;
   logic                       w_sample;
   logic signed [DATA_W-1:0]   w_shifted;
   logic [DATA_W-1:0]          w_result;

   // Write side
   wr_state_e                  r_state;
   wr_state_e                  w_state_d;
   logic [15:0]                r_wr_left;
   logic [15:0]                w_wr_left_d;
   logic [AXI_ADDR_W-1:0]      r_next_addr;
   logic [AXI_ADDR_W-1:0]      r_burst_addr;
   logic [7:0]                 r_len;
   logic                       r_zero_job;
   logic                       w_pop;
   logic                       w_drop;
   logic                       w_full;
   logic                       w_empty;
   logic [LVL_W-1:0]           w_level;
   logic [15:0]                w_level_ext;
   logic [15:0]                w_blen;
   logic [15:0]                w_beats;
   logic [DATA_W-1:0]          w_head;
   logic                       w_cap_done;
   logic                       w_burst_start;

   assign w_sample  = r_cap_active && (r_delay_cnt <= 32'd1);
   assign w_shifted = $signed(i_in0) >>> r_shift;
   assign w_result  = (r_relu && w_shifted[DATA_W-1]) ? '0 : w_shifted;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_delay_cnt  <= '0;
         r_period     <= 10'd1;
         r_cap_left   <= '0;
         r_cap_active <= 1'b0;
         r_shift      <= '0;
         r_relu       <= 1'b0;
         r_stage_vld  <= 1'b0;
         r_stage_data <= '0;
      end else if (i_run) begin
         r_delay_cnt  <= i_delay0;
         r_period     <= (i_period == '0) ? 10'd1 : i_period;
         r_cap_left   <= i_amount;
         r_cap_active <= (i_amount != '0);
         r_shift      <= i_shift;
         r_relu       <= i_relu;
         r_stage_vld  <= 1'b0;
      end else begin
         r_stage_vld <= w_sample;
         if (w_sample) r_stage_data <= w_result;
         if (w_sample) begin
            r_delay_cnt  <= {22'd0, r_period};
            r_cap_left   <= r_cap_left - 16'd1;
            r_cap_active <= (r_cap_left != 16'd1);
         end else if (r_cap_active) begin
            r_delay_cnt <= r_delay_cnt - 32'd1;
         end
      end
   end

   conv_wr_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (i_run),
      .i_push  (r_stage_vld),
      .i_pop   (w_pop),
      .i_data  (r_stage_data),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   assign w_pop       = (r_state == StBurst) && databus.ready;
   // Dropped samples still count as captured, so they come off the write budget.
   assign w_drop      = r_stage_vld && w_full && !w_pop;
   assign w_wr_left_d = r_wr_left - {15'd0, w_pop} - {15'd0, w_drop};
   assign w_level_ext = 16'(w_level);
   assign w_blen      = calc_blen(r_next_addr[11:0], r_wr_left, MAX_BURST, BYTES);
   assign w_beats     = (w_level_ext >= w_blen) ? w_blen : w_level_ext;
   assign w_cap_done  = !r_cap_active && !r_stage_vld;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= StIdle;
      else          r_state <= w_state_d;
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  w_state_d = StIdle;
         StWait: begin
            if (r_wr_left == '0) begin
               w_state_d = StDone;
            end else if (w_level_ext >= w_blen || (w_cap_done && !w_empty)) begin
               w_state_d = StBurst;
            end
         end
         StBurst: begin
            if (databus.ready && databus.last) w_state_d = (w_wr_left_d == '0) ? StDone : StWait;
         end
         StDone:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
      // A new run always wins, aborting whatever job is in flight.
      if (i_run) w_state_d = (i_amount != '0) ? StWait : StIdle;
   end

   assign w_burst_start = (r_state == StWait) && (w_state_d == StBurst);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_left    <= '0;
         r_next_addr  <= '0;
         r_burst_addr <= '0;
         r_len        <= '0;
         r_overflow   <= 1'b0;
         r_zero_job   <= 1'b0;
      end else begin
         r_zero_job <= i_run && (i_amount == '0);
         if (i_run) begin
            r_wr_left   <= i_amount;
            r_next_addr <= i_ext_addr;
            r_overflow  <= 1'b0;
         end else begin
            r_wr_left <= w_wr_left_d;
            if (w_pop)  r_next_addr <= r_next_addr + AXI_ADDR_W'(BYTES);
            if (w_drop) r_overflow  <= 1'b1;
         end
         if (w_burst_start) begin
            r_burst_addr <= r_next_addr;
            r_len        <= 8'(w_beats - 16'd1);
         end
      end
   end

   always_comb begin
      databus.valid = 1'b0;
      databus.addr  = '0;
      databus.len   = '0;
      databus.wdata = '0;
      databus.wstrb = '0;
      o_done        = 1'b0;
      unique case (r_state)
         StIdle:  o_done = !r_zero_job;
         StBurst: begin
            databus.valid = 1'b1;
            databus.addr  = r_burst_addr;
            databus.len   = r_len;
            databus.wdata = w_head;
            databus.wstrb = '1;
         end
         default: ;
      endcase
   end

   assign o_overflow = r_overflow;

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer: a burst-recording memory slave plus one task per scenario.
module tb_conv_result_writer;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned AXI_ADDR_W = 32;
   localparam logic [31:0] EXP_A [3] = '{32'h0000_0FC0, 32'h0000_1000, 32'h0000_1040};
   localparam logic [7:0]  EXP_L [3] = '{8'd15, 8'd15, 8'd7};

   logic                  clk      = 1'b0;
   logic                  rst_n    = 1'b0;
   logic                  run      = 1'b0;
   logic                  done;
   logic                  overflow;
   logic [DATA_W-1:0]     in0      = 32'd99;
   logic [AXI_ADDR_W-1:0] ext_addr = '0;
   logic [15:0]           amount   = '0;
   logic [9:0]            period   = '0;
   logic [31:0]           delay0   = '0;
   logic [4:0]            shift    = '0;
   logic                  relu     = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   int unsigned           tb_beat  = 0;
   int unsigned           beat_nxt;
   int unsigned           stab_err = 0;
   logic [AXI_ADDR_W-1:0] cur_addr = '0;
   logic [7:0]            cur_len  = '0;
   logic [31:0]           bq_addr [$];
   logic [7:0]            bq_len  [$];
   logic [31:0]           dq      [$];

   conv_result_writer_if #(.DATA_W(DATA_W), .AXI_ADDR_W(AXI_ADDR_W)) bus ();

   assign bus.last = bus.ready && (tb_beat == 32'(bus.len));

   conv_result_writer #(
      .DATA_W     (DATA_W),
      .AXI_ADDR_W (AXI_ADDR_W),
      .FIFO_DEPTH (16),
      .MAX_BURST  (16)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_run      (run),
      .o_done     (done),
      .i_in0      (in0),
      .i_ext_addr (ext_addr),
      .i_amount   (amount),
      .i_period   (period),
      .i_delay0   (delay0),
      .i_shift    (shift),
      .i_relu     (relu),
      .o_overflow (overflow),
      .databus    (bus)
   );

   always #5 clk = ~clk;

   // Memory slave: records each accepted beat 1 time unit before the rising edge.
   always begin
      @(negedge clk);
      #4;
      beat_nxt = 0;
      if (bus.valid) begin
         if (tb_beat != 0 && (bus.addr !== cur_addr || bus.len !== cur_len)) stab_err++;
         beat_nxt = tb_beat;
         if (bus.ready) begin
            if (tb_beat == 0) begin
               bq_addr.push_back(bus.addr);
               bq_len.push_back(bus.len);
               cur_addr = bus.addr;
               cur_len  = bus.len;
            end
            dq.push_back(bus.wdata);
            beat_nxt = bus.last ? 0 : tb_beat + 1;
         end
      end
      @(posedge clk);
      #1;
      tb_beat = beat_nxt;
   end

   task automatic start_run(input logic [31:0] a, input logic [15:0] amt, input logic [9:0] per,
                            input logic [31:0] dly, input logic [4:0] sh, input logic rl);
      @(negedge clk);
      ext_addr = a;
      amount   = amt;
      period   = per;
      delay0   = dly;
      shift    = sh;
      relu     = rl;
      run      = 1'b1;
      bq_addr.delete();
      bq_len.delete();
      dq.delete();
      stab_err = 0;
      @(negedge clk);
      run = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc);
      int n = 0;
      while (done !== 1'b1 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      #12;
      n_tests++;
      if (done !== 1'b1 || overflow !== 1'b0 || bus.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: done=%b ovf=%b valid=%b, want 1 0 0", done, overflow, bus.valid);
      end
      n_tests++;
      if (bus.addr !== '0 || bus.len !== '0 || bus.wdata !== '0 || bus.wstrb !== '0) begin
         n_fail++;
         $display("FAIL reset_bus: addr=%h len=%h wdata=%h wstrb=%h, want all 0",
                  bus.addr, bus.len, bus.wdata, bus.wstrb);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [31:0] got;
      bus.ready = 1'b1;
      in0 = 32'd99;
      start_run(32'h100, 16'd4, 10'd1, 32'd2, 5'd0, 1'b0);
      n_tests++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_busy: done=%b want 0", done);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in0 = 32'(10 + i);
      end
      wait_done(60);
      n_tests++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_done: done=%b want 1", done);
      end
      n_tests++;
      if (bq_addr.size() != 1 || bq_addr[0] !== 32'h100 || bq_len[0] !== 8'd3) begin
         n_fail++;
         $display("FAIL basic_burst: bursts=%0d addr=%h len=%0d, want 1 100 3", bq_addr.size(),
                  (bq_addr.size() > 0) ? bq_addr[0] : 32'hx, (bq_len.size() > 0) ? bq_len[0] : 8'hx);
      end
      for (int i = 0; i < 4; i++) begin
         got = (i < dq.size()) ? dq[i] : 32'hDEAD_BEEF;
         n_tests++;
         if (got !== 32'(10 + i)) begin
            n_fail++;
            $display("FAIL basic_data%0d: got %0d want %0d", i, got, 10 + i);
         end
      end
   endtask

   task automatic test_shift_relu();
      logic [31:0] exp_v [3] = '{32'hFFFF_FFF8, 32'h0, 32'd25};
      logic [31:0] in_v  [3] = '{32'hFFFF_FFC0, 32'hFFFF_FFC0, 32'd100};
      logic [4:0]  sh_v  [3] = '{5'd3, 5'd3, 5'd2};
      logic        rl_v  [3] = '{1'b0, 1'b1, 1'b1};
      logic [31:0] got;
      bus.ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in0 = in_v[k];
         start_run(32'h200, 16'd1, 10'd1, 32'd0, sh_v[k], rl_v[k]);
         wait_done(40);
         got = (dq.size() == 1) ? dq[0] : 32'hDEAD_BEEF;
         n_tests++;
         if (got !== exp_v[k] || done !== 1'b1) begin
            n_fail++;
            $display("FAIL shift_relu%0d: got %h (words=%0d done=%b) want %h", k, got, dq.size(),
                     done, exp_v[k]);
         end
      end
   endtask

   task automatic test_4k_split();
      bus.ready = 1'b1;
      in0 = 32'd5;
      start_run(32'hFC0, 16'd40, 10'd2, 32'd0, 5'd0, 1'b0);
      wait_done(400);
      n_tests++;
      if (done !== 1'b1 || bq_addr.size() != 3 || dq.size() != 40 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL split_count: done=%b bursts=%0d words=%0d ovf=%b, want 1 3 40 0", done,
                  bq_addr.size(), dq.size(), overflow);
      end
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (i >= bq_addr.size() || bq_addr[i] !== EXP_A[i] || bq_len[i] !== EXP_L[i]) begin
            n_fail++;
            $display("FAIL split_burst%0d: addr=%h len=%0d, want %h %0d", i,
                     (i < bq_addr.size()) ? bq_addr[i] : 32'hx,
                     (i < bq_len.size()) ? bq_len[i] : 8'hx, EXP_A[i], EXP_L[i]);
         end
      end
      n_tests++;
      if (stab_err != 0) begin
         n_fail++;
         $display("FAIL split_stable: %0d addr/len changes within a burst, want 0", stab_err);
      end
   endtask

   task automatic test_overflow();
      bus.ready = 1'b0;
      in0 = 32'd3;
      start_run(32'h0, 16'd20, 10'd1, 32'd0, 5'd0, 1'b0);
      repeat (30) @(negedge clk);
      n_tests++;
      if (overflow !== 1'b1 || bus.valid !== 1'b1 || bus.len !== 8'd15) begin
         n_fail++;
         $display("FAIL ovf_flag: ovf=%b valid=%b len=%0d, want 1 1 15", overflow, bus.valid,
                  bus.len);
      end
      bus.ready = 1'b1;
      wait_done(100);
      n_tests++;
      if (done !== 1'b1 || dq.size() != 16 || bq_addr.size() != 1 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_written: done=%b words=%0d bursts=%0d ovf=%b, want 1 16 1 1", done,
                  dq.size(), bq_addr.size(), overflow);
      end
   endtask

   task automatic test_abort();
      bus.ready = 1'b0;
      in0 = 32'd3;
      start_run(32'h200, 16'd20, 10'd1, 32'd0, 5'd0, 1'b0);
      repeat (25) @(negedge clk);
      bus.ready = 1'b1;
      repeat (2) @(negedge clk);
      bus.ready = 1'b0;
      n_tests++;
      if (bus.valid !== 1'b1 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_pre: valid=%b ovf=%b, want 1 1", bus.valid, overflow);
      end
      in0 = 32'd7;
      start_run(32'h800, 16'd3, 10'd1, 32'd0, 5'd0, 1'b0);
      n_tests++;
      if (bus.valid !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_drop: valid=%b ovf=%b, want 0 0", bus.valid, overflow);
      end
      bus.ready = 1'b1;
      wait_done(60);
      n_tests++;
      if (done !== 1'b1 || bq_addr.size() != 1 || bq_addr[0] !== 32'h800 || bq_len[0] !== 8'd2
          || dq.size() != 3 || dq[0] !== 32'd7 || dq[2] !== 32'd7 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_newjob: done=%b bursts=%0d words=%0d ovf=%b, want 1 1@800 len2 3x7 0",
                  done, bq_addr.size(), dq.size(), overflow);
      end
   endtask

   task automatic test_reset_mid();
      bus.ready = 1'b0;
      in0 = 32'd1;
      start_run(32'h300, 16'd20, 10'd1, 32'd0, 5'd0, 1'b0);
      repeat (20) @(negedge clk);
      n_tests++;
      if (bus.valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_pre: valid=%b want 1", bus.valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (bus.valid !== 1'b0 || bus.addr !== '0 || bus.len !== '0 || bus.wdata !== '0
          || bus.wstrb !== '0 || done !== 1'b1 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_async: valid=%b addr=%h len=%h wdata=%h wstrb=%h done=%b ovf=%b",
                  bus.valid, bus.addr, bus.len, bus.wdata, bus.wstrb, done, overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      start_run(32'h0, 16'd0, 10'd1, 32'd0, 5'd0, 1'b0);
      n_tests++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_drop: done=%b want 0", done);
      end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b1 || bus.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_back: done=%b valid=%b, want 1 0", done, bus.valid);
      end
   endtask

   initial begin
      bus.ready = 1'b0;
      test_reset();
      test_basic();
      test_shift_relu();
      test_4k_split();
      test_overflow();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
